y86_instr_encoder: RTL and testbench

- Inverse of the SEQ fetch stage: accepts one decoded Y86-64 instruction (icode, ifun, rA, rB, valC) per handshake and serialises it into the byte-wide instruction memory image that fetch reads.
- Writes one byte per cycle through a write port and keeps an auto-advancing write pointer, so a testbench or loader can build programs in memory without preparing hand-assembled binary files.
- Byte layout, instruction lengths and validity checks match fetch exactly, so encoded bytes decode back to identical fields.

---
 rtl/y86_pkg.sv | 35 +++
 rtl/y86_instr_len_chk.sv | 21 ++
 rtl/y86_instr_encoder.sv | 125 ++++++++++++
 tb/tb_y86_instr_encoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Y86-64 instruction codes, register sentinel, encoder state type and the
// instruction-length lookup used by both the encoder and fetch (valP).
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } enc_state_e;

  // Undefined icodes report 1 byte; callers qualify with the legality check.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_CMOV, I_OP, I_PUSH, I_POP: instr_len = 4'd2;
      I_JXX, I_CALL:               instr_len = 4'd9;
      I_IRMOV, I_RMMOV, I_MRMOV:   instr_len = 4'd10;
      default:                     instr_len = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/y86_instr_len_chk.sv
// Combinational instruction length and icode/ifun legality check, shared
// between the encoder and the fetch stage.
module y86_instr_len_chk
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  output logic [3:0] len,
  output logic       legal
);

  always_comb begin
    len = instr_len(icode);
    case (icode)
      I_OP:          legal = (ifun <= 4'd3);
      I_CMOV, I_JXX: legal = (ifun <= 4'd6);
      default:       legal = (icode <= I_POP) && (ifun == 4'd0);
    endcase
  end

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialises one decoded Y86-64 instruction per handshake into byte writes
// at an auto-advancing write pointer, mirroring the fetch-stage byte layout.
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshake: an instruction is taken on a rising edge where in_valid and
  // in_ready are both high; fields need only be stable for that edge.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              done,
  output logic              invalid_inst,
  output logic              imem_error,
  output enc_state_e        dbg_state
);

  localparam int AW1 = ADDR_W + 1;

  enc_state_e  state, state_d;
  logic [3:0]  idx, len_r, icode_r, ifun_r, ra_r, rb_r;
  logic [63:0] valc_r;
  logic [3:0]  len_in;
  logic        legal_in, accept, fits, last, has_reg;
  logic [AW1-1:0] end_excl;
  logic [2:0]  c_idx;
  logic [7:0]  byte_sel;

  y86_instr_len_chk u_len_chk (
    .icode (icode),
    .ifun  (ifun),
    .len   (len_in),
    .legal (legal_in)
  );

  assign in_ready = (state == S_IDLE) && !base_load;
  assign accept   = in_valid && in_ready;

  // One extra bit keeps the end address from wrapping before the compare.
  assign end_excl = {1'b0, wr_ptr} + AW1'(len_in);
  assign fits     = (end_excl <= AW1'(MEM_DEPTH));
  assign last     = (state == S_EMIT) && (idx == len_r - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (accept && legal_in && fits) state_d = S_EMIT;
      S_EMIT:  if (last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      idx          <= '0;
      len_r        <= '0;
      icode_r      <= '0;
      ifun_r       <= '0;
      ra_r         <= '0;
      rb_r         <= '0;
      valc_r       <= '0;
      invalid_inst <= 1'b0;
      imem_error   <= 1'b0;
    end else begin
      invalid_inst <= accept && !legal_in;
      imem_error   <= accept && legal_in && !fits;
      if (state == S_IDLE) begin
        if (base_load) begin
          wr_ptr <= base_addr;
        end else if (accept) begin
          icode_r <= icode;
          ifun_r  <= ifun;
          ra_r    <= (icode == I_IRMOV) ? RNONE : rA;
          rb_r    <= (icode == I_PUSH || icode == I_POP) ? RNONE : rB;
          valc_r  <= valC;
          len_r   <= len_in;
          idx     <= '0;
        end
      end else begin
        idx <= idx + 4'd1;
        if (last) begin
          wr_ptr <= wr_ptr + ADDR_W'(len_r);
          idx    <= '0;
        end
      end
    end
  end

  // valC starts at byte 2 when a register byte is present, else at byte 1.
  assign has_reg = (len_r == 4'd2) || (len_r == 4'd10);
  assign c_idx   = has_reg ? 3'(idx - 4'd2) : 3'(idx - 4'd1);

  always_comb begin
    byte_sel = valc_r[{c_idx, 3'b000} +: 8];
    if (idx == 4'd0)                 byte_sel = {icode_r, ifun_r};
    else if (has_reg && idx == 4'd1) byte_sel = {ra_r, rb_r};
  end

  assign mem_we    = (state == S_EMIT);
  assign mem_addr  = mem_we ? wr_ptr + ADDR_W'(idx) : '0;
  assign mem_wdata = mem_we ? byte_sel : '0;
  assign done      = last;
  assign dbg_state = state;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Bench for y86_instr_encoder: directed programs plus random instructions,
// checked against a byte-image model built from the Y86-64 encoding rules.
module tb_y86_instr_encoder;
  import y86_pkg::*;

  localparam int ADDR_W    = 10;
  localparam int MEM_DEPTH = 1024;
  localparam int W         = ADDR_W + 8;

  logic              clk, rst_n, in_valid, in_ready, base_load;
  logic [3:0]        icode, ifun, rA, rB;
  logic [63:0]       valC;
  logic [ADDR_W-1:0] base_addr, mem_addr, wr_ptr;
  logic              mem_we, done, invalid_inst, imem_error;
  logic [7:0]        mem_wdata;
  enc_state_e        dbg_state;

  y86_instr_encoder #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .icode        (icode),
    .ifun         (ifun),
    .rA           (rA),
    .rB           (rB),
    .valC         (valC),
    .base_load    (base_load),
    .base_addr    (base_addr),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .wr_ptr       (wr_ptr),
    .done         (done),
    .invalid_inst (invalid_inst),
    .imem_error   (imem_error),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks, n_fail, wr_count, exp_wr_count, model_ptr;
  logic [W-1:0] exp_q[$];
  logic [7:0]   tb_mem    [MEM_DEPTH];
  logic [7:0]   model_mem [MEM_DEPTH];
  int len_tab [12] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2};
  int max_fun [12] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory as fetch would see it: only writes that reach a clock edge land.
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      wr_count++;
      tb_mem[mem_addr] = mem_wdata;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_base(input int a);
    @(negedge clk);
    base_load = 1'b1;
    base_addr = ADDR_W'(a);
    #1 check("ready_during_base_load", in_ready, 0);
    @(posedge clk);
    #1 base_load = 1'b0;
    model_ptr = a;
  endtask

  // Sends one instruction; abort_at >= 0 pulls reset during that byte index.
  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc, input int abort_at);
    int len, t, addr;
    bit legal, fits;
    logic [7:0] b[$];
    logic [W-1:0] e;
    legal = (ic <= 4'hB) ? (int'(fn) <= max_fun[ic]) : 1'b0;
    len   = (ic <= 4'hB) ? len_tab[ic] : 1;
    fits  = (model_ptr + len) <= MEM_DEPTH;
    b.push_back({ic, fn});
    if (len == 2 || len == 10)
      b.push_back({(ic == I_IRMOV) ? 4'hF : ra, (ic == I_PUSH || ic == I_POP) ? 4'hF : rb});
    if (len >= 9)
      for (int i = 0; i < 8; i++) b.push_back(8'(vc / (64'd1 << (8 * i))));

    @(negedge clk);
    check("idle_outputs", {mem_we, done, invalid_inst, imem_error}, 0);
    check("wr_ptr", wr_ptr, model_ptr);
    icode = ic; ifun = fn; rA = ra; rB = rb; valC = vc; in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    icode = 4'($urandom); ifun = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
    valC = {$urandom, $urandom};

    if (!legal) begin
      @(negedge clk);
      check("invalid_inst_pulse", {invalid_inst, imem_error}, 2'b10);
      check("reject_no_write", mem_we, 0);
      return;
    end
    if (!fits) begin
      @(negedge clk);
      check("imem_error_pulse", {invalid_inst, imem_error}, 2'b01);
      check("overflow_no_write", mem_we, 0);
      return;
    end

    for (int k = 0; k < len; k++) begin
      addr = (model_ptr + k) % MEM_DEPTH;
      exp_q.push_back({ADDR_W'(addr), b[k]});
    end
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (k == abort_at) begin
        check("pre_abort_we", mem_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_we", mem_we, 0);
        check("abort_wr_ptr", wr_ptr, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready", in_ready, 1);
        check("abort_state", dbg_state, S_IDLE);
        exp_q.delete();
        model_ptr = 0;
        return;
      end
      check("we", mem_we, 1);
      check("addr", mem_addr, e[W-1:8]);
      check("data", mem_wdata, e[7:0]);
      check("done", done, (k == len - 1));
      check("ready_low_in_emit", in_ready, 0);
      model_mem[e[W-1:8]] = e[7:0];
      exp_wr_count++;
    end
    model_ptr = (model_ptr + len) % MEM_DEPTH;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ic, fn, mism;
    n_checks = 0; n_fail = 0; wr_count = 0; exp_wr_count = 0; model_ptr = 0;
    rst_n = 1'b0; in_valid = 1'b0; base_load = 1'b0; base_addr = '0;
    icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      tb_mem[i] = 8'h00;
      model_mem[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("reset_wr_ptr", wr_ptr, 0);
    check("reset_flags", {mem_we, done, invalid_inst, imem_error}, 0);
    check("reset_addr_data", {mem_addr, mem_wdata}, 0);
    check("reset_state", dbg_state, S_IDLE);
    rst_n = 1'b1;

    send(I_IRMOV, 4'h0, 4'h5, 4'h3, 64'h0123456789ABCDEF, -1);
    @(posedge clk);
    #1;
    check("irmovq_b0", tb_mem[0], 8'h30);
    check("irmovq_b1", tb_mem[1], 8'hF3);
    check("irmovq_b2", tb_mem[2], 8'hEF);
    check("irmovq_b9", tb_mem[9], 8'h01);

    rst_n = 1'b0;
    #1 model_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    send(I_HALT, 4'h0, 4'h0, 4'h0, 64'h0, -1);
    send(I_JXX, 4'h4, 4'h0, 4'h0, 64'h100, -1);
    send(I_OP, 4'h5, 4'h1, 4'h2, 64'h0, -1);
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'h0, -1);

    load_base(1015);
    send(I_RMMOV, 4'h0, 4'h1, 4'h2, 64'h55, -1);
    send(I_PUSH, 4'h0, 4'h2, 4'h7, 64'h0, -1);
    load_base(1014);
    send(I_MRMOV, 4'h0, 4'h3, 4'h4, 64'hDEADBEEF_CAFEF00D, -1);
    send(I_CALL, 4'h0, 4'h0, 4'h0, 64'h1234, 3);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) load_base($urandom_range(990, 1023));
      ic = $urandom_range(0, 13);
      if ($urandom_range(0, 3) == 0) fn = $urandom_range(0, 15);
      else fn = (ic <= 11) ? $urandom_range(0, max_fun[ic]) : 0;
      send(4'(ic), 4'(fn), 4'($urandom), 4'($urandom), {$urandom, $urandom}, -1);
    end

    @(negedge clk);
    check("final_wr_ptr", wr_ptr, model_ptr);
    check("write_count", wr_count, exp_wr_count);
    mism = 0;
    for (int i = 0; i < MEM_DEPTH; i++)
      if (tb_mem[i] !== model_mem[i]) mism++;
    check("mem_image_mismatches", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
